// File: rtl/ip4_axi_slv_wr.sv
// AXI3 write slave: accepts one AW burst, splits its W beats into single-beat internal writes, then returns B.
// Macro IP4_AXI_WRAP_EN enables WRAP bursts; without it WRAP bursts are consumed and answered with SLVERR.
module ip4_axi_slv_wr #(
    parameter int unsigned WID_AXI_ID   = 4,
    parameter int unsigned WID_AXI_ADDR = 32,
    parameter int unsigned WID_AXI_DATA = 64
) (
    input  logic                        aclk,
    input  logic                        rst,
    input  logic [WID_AXI_ID-1:0]       awid,
    input  logic [WID_AXI_ADDR-1:0]     awaddr,
    input  logic [3:0]                  awlen,
    input  logic [2:0]                  awsize,
    input  logic [1:0]                  awburst,
    input  logic [1:0]                  awlock,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [WID_AXI_ID-1:0]       wid,
    input  logic [WID_AXI_DATA-1:0]     wdata,
    input  logic [WID_AXI_DATA/8-1:0]   wstrb,
    input  logic                        wlast,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [WID_AXI_ID-1:0]       bid,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    output logic                        wr_vld,
    output logic [WID_AXI_ADDR-1:0]     wr_addr,
    output logic [WID_AXI_DATA-1:0]     wr_data,
    output logic [WID_AXI_DATA/8-1:0]   wr_strb,
    input  logic                        wr_rdy
);

    localparam int unsigned BYTES_AXI_DATA = WID_AXI_DATA / 8;
    localparam int unsigned SIZE_MAX       = $clog2(BYTES_AXI_DATA);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [WID_AXI_ID-1:0]      r_id;
    logic [WID_AXI_ADDR-1:0]    r_addr;
    logic [3:0]                 r_len;
    logic [2:0]                 r_size;
    logic [1:0]                 r_burst;
    logic [3:0]                 r_cnt;
    logic                       r_err;
    logic                       r_done;

    logic                       r_awready;
    logic                       r_bvalid;
    logic [WID_AXI_ID-1:0]      r_bid;
    logic [1:0]                 r_bresp;
    logic                       r_wr_vld;
    logic [WID_AXI_ADDR-1:0]    r_wr_addr;
    logic [WID_AXI_DATA-1:0]    r_wr_data;
    logic [BYTES_AXI_DATA-1:0]  r_wr_strb;

    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_wr_free;
    logic                       w_beat_last;
    logic                       w_beat_err;
    logic                       w_beat_ok;
    logic                       w_cap_err;
    logic [WID_AXI_ADDR-1:0]    w_beat_bytes;
    logic [WID_AXI_ADDR-1:0]    w_addr_nxt;
    logic                       w_unused;

    // Lock is accepted but exclusive access is not supported.
    assign w_unused = ^awlock;

    assign w_aw_hs     = awvalid & r_awready;
    assign w_wr_free   = ~r_wr_vld | wr_rdy;
    assign w_w_hs      = wvalid & wready;
    assign w_beat_last = (r_cnt == r_len);
    assign w_beat_err  = (wid != r_id) | (wlast != w_beat_last);
    assign w_beat_ok   = w_w_hs & ~r_err & (wid == r_id);

    assign awready = r_awready;
    assign wready  = (r_state == S_DATA) & ~r_done & w_wr_free;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;
    assign wr_vld  = r_wr_vld;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign wr_strb = r_wr_strb;

    // Burst attributes that make the whole burst unserviceable.
    always_comb begin
        w_cap_err = 1'b0;
        if (awsize > 3'(SIZE_MAX)) begin
            w_cap_err = 1'b1;
        end
        if (awburst == BURST_WRAP) begin
`ifdef IP4_AXI_WRAP_EN
            if (!((awlen == 4'd1) || (awlen == 4'd3) || (awlen == 4'd7) || (awlen == 4'd15))) begin
                w_cap_err = 1'b1;
            end
`else
            w_cap_err = 1'b1;
`endif
        end else if ((awburst != BURST_FIXED) && (awburst != BURST_INCR)) begin
            w_cap_err = 1'b1;
        end
    end

    assign w_beat_bytes = WID_AXI_ADDR'(1) << r_size;

`ifdef IP4_AXI_WRAP_EN
    logic [WID_AXI_ADDR-1:0]    w_wrap_mask;

    assign w_wrap_mask = ((WID_AXI_ADDR'(r_len) + WID_AXI_ADDR'(1)) << r_size) - WID_AXI_ADDR'(1);
`endif

    // Address of the beat after the current one.
    always_comb begin
        w_addr_nxt = r_addr;
        if (r_burst == BURST_INCR) begin
            w_addr_nxt = r_addr + w_beat_bytes;
        end
`ifdef IP4_AXI_WRAP_EN
        else if (r_burst == BURST_WRAP) begin
            w_addr_nxt = (r_addr & ~w_wrap_mask) | ((r_addr + w_beat_bytes) & w_wrap_mask);
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response waits until the last internal write has left the output register.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_aw_hs) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_done && w_wr_free) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_bvalid && bready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_awready <= (w_state_nxt == S_IDLE);
            r_bvalid  <= (w_state_nxt == S_RESP);
            if (w_aw_hs) begin
                r_id    <= awid;
                r_addr  <= awaddr;
                r_len   <= awlen;
                r_size  <= awsize;
                r_burst <= awburst;
                r_cnt   <= '0;
                r_err   <= w_cap_err;
                r_done  <= 1'b0;
            end else if (w_w_hs) begin
                r_addr <= w_addr_nxt;
                r_cnt  <= r_cnt + 4'd1;
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
                if (w_beat_last) begin
                    r_done <= 1'b1;
                end
            end
            if ((r_state == S_DATA) && (w_state_nxt == S_RESP)) begin
                r_bid   <= r_id;
                r_bresp <= r_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Single output register: a new beat may reload it in the cycle the old one drains.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_strb <= '0;
        end else begin
            if (w_beat_ok) begin
                r_wr_vld  <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= wdata;
                r_wr_strb <= wstrb;
            end else if (wr_rdy) begin
                r_wr_vld  <= 1'b0;
            end
        end
    end

endmodule
